// File: rtl/gpio_pkg.sv
// gpio_pkg: register indices and bus geometry shared by the GPIO controller files.
package gpio_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] REG_OUT     = 3'd0;
  localparam logic [ADDR_W-1:0] REG_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] REG_IN      = 3'd2;
  localparam logic [ADDR_W-1:0] REG_IRQ_EN  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_IRQ_POL = 3'd4;
  localparam logic [ADDR_W-1:0] REG_IRQ_ST  = 3'd5;
  localparam logic [ADDR_W-1:0] REG_SET     = 3'd6;
  localparam logic [ADDR_W-1:0] REG_CLR     = 3'd7;
endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: input synchroniser plus optional per-pin debounce (GPIO_DEBOUNCE_EN).
module gpio_in_filter #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] filt,
  output logic [WIDTH-1:0] filt_nxt
);
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      filt <= '0;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      filt <= filt_nxt;
    end
  end
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [WIDTH-1:0] s_prev;
  logic [CW-1:0]    cnt [WIDTH];
  // counter restarts whenever the pin agrees with filt or is still moving
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s_prev <= s;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= (s[i] == filt[i] || s[i] != s_prev[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
  always_comb begin
    filt_nxt = filt;
    for (int i = 0; i < WIDTH; i++)
      filt_nxt[i] = (cnt[i] == CW'(DEBOUNCE_CYCLES - 1) && s[i] != filt[i] && s[i] == s_prev[i]) ? s[i] : filt[i];
  end
`else
  localparam int unused_dbc = DEBOUNCE_CYCLES;
  assign filt_nxt = s;
`endif
endmodule

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: memory-mapped GPIO with direction, set/clear, edge interrupts.
// Optional debounce on inputs is compiled in with GPIO_DEBOUNCE_EN.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  input  logic [WIDTH-1:0]  gpio_port_in,
  output logic [WIDTH-1:0]  gpio_port_out,
  output logic [WIDTH-1:0]  gpio_port_oe,
  output logic              irq
);
  logic [WIDTH-1:0] out_r, dir_r, en_r, pol_r, stat_r;
  logic [WIDTH-1:0] filt, filt_nxt, edges, wd, sel;
  logic [DATA_W-1:0] rd;
  logic wr;
  logic unused_wdata;
  gpio_in_filter #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk(clk), .rst(rst), .din(gpio_port_in), .filt(filt), .filt_nxt(filt_nxt)
  );
  assign unused_wdata = ^bus_wdata;
  assign wd = bus_wdata[WIDTH-1:0];
  assign wr = bus_req & bus_we;
  // filt is the held value; an edge is a change whose new level matches the polarity
  assign edges = (filt_nxt ^ filt) & ~(filt_nxt ^ pol_r);
  assign irq = |(stat_r & en_r);
  assign gpio_port_out = out_r;
  assign gpio_port_oe = dir_r;
  always_comb begin
    sel = bus_addr == REG_OUT     ? out_r  :
          bus_addr == REG_DIR     ? dir_r  :
          bus_addr == REG_IN      ? filt   :
          bus_addr == REG_IRQ_EN  ? en_r   :
          bus_addr == REG_IRQ_POL ? pol_r  :
          bus_addr == REG_IRQ_ST  ? stat_r : '0;
    rd = '0;
    rd[WIDTH-1:0] = sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ack <= 1'b0;
      bus_rdata <= '0;
      out_r <= '0;
      dir_r <= '0;
      en_r <= '0;
      pol_r <= '0;
      stat_r <= '0;
    end else begin
      bus_ack <= bus_req;
      bus_rdata <= (bus_req && !bus_we) ? rd : '0;
      if (wr && bus_addr == REG_OUT) out_r <= wd;
      else if (wr && bus_addr == REG_SET) out_r <= out_r | wd;
      else if (wr && bus_addr == REG_CLR) out_r <= out_r & ~wd;
      if (wr && bus_addr == REG_DIR) dir_r <= wd;
      if (wr && bus_addr == REG_IRQ_EN) en_r <= wd;
      if (wr && bus_addr == REG_IRQ_POL) pol_r <= wd;
      stat_r <= (stat_r & ~((wr && bus_addr == REG_IRQ_ST) ? wd : '0)) | edges;
    end
  end
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl: scoreboard bench for gpio_port_ctrl (default and WIDTH=4 instances).
module tb_gpio_port_ctrl;
  import gpio_pkg::*;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + 1 + 16;
`else
  localparam int LAT = 2 + 1;
`endif
  logic clk = 0, rst = 1;
  logic bus_req = 0, bus_we = 0, bus_ack, irq;
  logic [2:0] bus_addr = 0;
  logic [31:0] bus_wdata = 0, bus_rdata;
  logic [7:0] pins = 0, gpio_port_out, gpio_port_oe;
  logic b4_req = 0, b4_we = 0, b4_ack, irq4;
  logic [2:0] b4_addr = 0;
  logic [31:0] b4_wdata = 0, b4_rdata;
  logic [3:0] pins4 = 0, out4, oe4;
  int checks = 0, errors = 0;
  logic [32:0] exp_q[$];
  logic exp_ack = 0, mon_on = 0;
  logic [32:0] ent;

  always #5 clk = ~clk;

  gpio_port_ctrl dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .gpio_port_in(pins), .gpio_port_out(gpio_port_out), .gpio_port_oe(gpio_port_oe), .irq(irq)
  );
  gpio_port_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus_req(b4_req), .bus_we(b4_we), .bus_addr(b4_addr),
    .bus_wdata(b4_wdata), .bus_rdata(b4_rdata), .bus_ack(b4_ack),
    .gpio_port_in(pins4), .gpio_port_out(out4), .gpio_port_oe(oe4), .irq(irq4)
  );

  always @(posedge clk) exp_ack <= bus_req && !rst;

  always @(negedge clk) if (mon_on) begin
    checks++;
    if (bus_ack !== exp_ack) begin
      errors++;
      $display("FAIL ack_timing t=%0t ack=%b expected=%b", $time, bus_ack, exp_ack);
    end
    if (bus_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow t=%0t unexpected ack", $time);
      end else begin
        ent = exp_q.pop_front();
        if (ent[32] && bus_rdata !== ent[31:0]) begin
          errors++;
          $display("FAIL rdata t=%0t got=%h expected=%h", $time, bus_rdata, ent[31:0]);
        end
      end
    end else begin
      checks++;
      if (bus_rdata !== 32'h0) begin
        errors++;
        $display("FAIL rdata_idle t=%0t got=%h expected=0", $time, bus_rdata);
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_req = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
    exp_q.push_back({1'b0, 32'h0});
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    @(negedge clk);
    bus_req = 1; bus_we = 0; bus_addr = a; bus_wdata = 0;
    exp_q.push_back({1'b1, e});
  endtask

  task automatic idle;
    @(negedge clk);
    bus_req = 0; bus_we = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gpio_port_out, gpio_port_oe, irq, bus_ack} !== 18'h0 || bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs out=%h oe=%h irq=%b ack=%b rdata=%h expected all 0",
               gpio_port_out, gpio_port_oe, irq, bus_ack, bus_rdata);
    end
    rst = 0;
    mon_on = 1;
    for (int i = 0; i < 8; i++) rd(3'(i), 32'h0);
    idle;
    checks++;
    if (irq !== 1'b0 || gpio_port_oe !== 8'h0) begin
      errors++;
      $display("FAIL reset_irq_oe irq=%b oe=%h expected 0/00", irq, gpio_port_oe);
    end
  endtask

  task automatic test_out;
    wr(REG_DIR, 32'hF0);
    wr(REG_OUT, 32'hA5);
    idle;
    checks++;
    if (gpio_port_oe !== 8'hF0 || gpio_port_out !== 8'hA5) begin
      errors++;
      $display("FAIL out_write oe=%h out=%h expected F0/A5", gpio_port_oe, gpio_port_out);
    end
    wr(REG_SET, 32'h0A);
    idle;
    checks++;
    if (gpio_port_out !== 8'hAF) begin
      errors++;
      $display("FAIL out_set out=%h expected AF", gpio_port_out);
    end
    wr(REG_CLR, 32'h80);
    idle;
    checks++;
    if (gpio_port_out !== 8'h2F) begin
      errors++;
      $display("FAIL out_clr out=%h expected 2F", gpio_port_out);
    end
    rd(REG_SET, 32'h0);
    rd(REG_CLR, 32'h0);
    rd(REG_OUT, 32'h2F);
    rd(REG_DIR, 32'hF0);
    wr(REG_IN, 32'hFF);
    rd(REG_IN, 32'h0);
    idle;
  endtask

  task automatic test_back_to_back;
    wr(REG_OUT, 32'h12);
    rd(REG_OUT, 32'h12);
    wr(REG_SET, 32'h1_0001);
    rd(REG_OUT, 32'h13);
    wr(REG_CLR, 32'h02);
    rd(REG_OUT, 32'h11);
    idle;
  endtask

  task automatic test_in;
    @(negedge clk);
    pins = 8'h03;
    repeat (LAT - 2) @(negedge clk);
    rd(REG_IN, 32'h0);
    rd(REG_IN, 32'h03);
    idle;
  endtask

  task automatic test_irq;
    wr(REG_IRQ_EN, 32'h01);
    wr(REG_IRQ_POL, 32'h01);
    idle;
    pins = 8'h02;
    repeat (LAT + 4) @(negedge clk);
    rd(REG_IRQ_ST, 32'h0);
    idle;
    pins = 8'h03;
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early irq=%b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise irq=%b expected 1", irq);
    end
    rd(REG_IRQ_ST, 32'h01);
    idle;
    pins = 8'h02;
    repeat (LAT + 4) @(negedge clk);
    pins = 8'h03;
    repeat (LAT - 2) @(negedge clk);
    wr(REG_IRQ_ST, 32'h01);
    idle;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_vs_edge irq=%b expected 1", irq);
    end
    rd(REG_IRQ_ST, 32'h01);
    wr(REG_IRQ_ST, 32'h01);
    idle;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear irq=%b expected 0", irq);
    end
    rd(REG_IRQ_ST, 32'h0);
    idle;
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    wr(REG_IRQ_POL, 32'h03);
    idle;
    pins = 8'h01;
    repeat (LAT + 4) @(negedge clk);
    wr(REG_IRQ_ST, 32'hFF);
    idle;
    pins = 8'h03;
    repeat (10) @(negedge clk);
    pins = 8'h01;
    repeat (LAT + 4) @(negedge clk);
    rd(REG_IN, 32'h01);
    rd(REG_IRQ_ST, 32'h0);
    idle;
    pins = 8'h03;
    repeat (LAT - 2) @(negedge clk);
    rd(REG_IN, 32'h01);
    rd(REG_IN, 32'h03);
    rd(REG_IRQ_ST, 32'h02);
    idle;
  endtask
`endif

  task automatic test_width4;
    @(negedge clk);
    b4_req = 1; b4_we = 1; b4_addr = REG_OUT; b4_wdata = 32'hFF;
    @(negedge clk);
    b4_we = 0; b4_wdata = 0;
    checks++;
    if (b4_ack !== 1'b1 || out4 !== 4'hF) begin
      errors++;
      $display("FAIL w4_write ack=%b out=%h expected 1/F", b4_ack, out4);
    end
    @(negedge clk);
    b4_req = 0;
    checks++;
    if (b4_ack !== 1'b1 || b4_rdata !== 32'h0F) begin
      errors++;
      $display("FAIL w4_read ack=%b rdata=%h expected 1/0000000F", b4_ack, b4_rdata);
    end
    @(negedge clk);
    b4_req = 1; b4_we = 1; b4_wdata = 32'h5; rst = 1;
    @(negedge clk);
    checks++;
    if (b4_ack !== 1'b0 || out4 !== 4'h0 || gpio_port_oe !== 8'h0) begin
      errors++;
      $display("FAIL mid_reset ack=%b out4=%h oe=%h expected 0/0/00", b4_ack, out4, gpio_port_oe);
    end
    rst = 0; b4_req = 0; b4_we = 0;
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_irq irq=%b expected 0", irq);
    end
  endtask

  initial begin
    test_reset;
    test_out;
    test_back_to_back;
    test_in;
    test_irq;
`ifdef GPIO_DEBOUNCE_EN
    test_debounce;
`endif
    test_width4;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
